// File: rtl/gift_round_ctrl_if.sv
// Round handshake and key/constant bus between the GIFT-128 round
// controller and the state datapath.
interface gift_round_ctrl_if;
    logic         start;
    logic [127:0] key_in;
    logic         round_ready;
    logic         round_valid;
    logic [4:0]   rcon;
    logic [5:0]   rc;
    logic [31:0]  rk_u;
    logic [31:0]  rk_v;
    logic         busy;
    logic         done;

    modport master (
        output start, key_in, round_ready,
        input  round_valid, rcon, rc, rk_u, rk_v, busy, done
    );

    modport slave (
        input  start, key_in, round_ready,
        output round_valid, rcon, rc, rk_u, rk_v, busy, done
    );
endinterface

// File: rtl/gift_round_ctrl.sv
// GIFT-128 round sequencer: round index, 6-bit LFSR constant and
// per-round key halves U/V under a start/ready/done handshake.
module gift_round_ctrl #(
    parameter int ROUNDS = 28
) (
    input  logic             clk,
    input  logic             rst,
    gift_round_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    localparam logic [4:0] LAST = 5'(ROUNDS);

    state_t         state_q, state_d;
    logic [4:0]     rcon_q, rcon_d;
    logic [5:0]     rc_q, rc_d;
    logic [127:0]   key_q, key_d;
    logic [15:0]    k1, k0;
    logic [127:0]   key_nxt;

    assign k1 = key_q[31:16];
    assign k0 = key_q[15:0];
    // k7' = k1 >>> 2, k6' = k0 >>> 12, the rest shift down two words
    assign key_nxt = {k1[1:0], k1[15:2], k0[11:0], k0[15:12], key_q[127:32]};

    always_comb begin
        state_d = state_q;
        rcon_d  = rcon_q;
        rc_d    = rc_q;
        key_d   = key_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    key_d   = bus.key_in;
                    rcon_d  = 5'd1;
                    rc_d    = 6'b000001;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (bus.round_ready) begin
                    if (rcon_q == LAST) begin
                        state_d = FIN;
                        rcon_d  = '0;
                        rc_d    = '0;
                        key_d   = '0;
                    end else begin
                        rcon_d = rcon_q + 5'd1;
                        rc_d   = {rc_q[4:0], rc_q[5] ^ rc_q[4] ^ 1'b1};
                        key_d  = key_nxt;
                    end
                end
            end
            FIN: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rcon_q  <= '0;
            rc_q    <= '0;
            key_q   <= '0;
        end else begin
            state_q <= state_d;
            rcon_q  <= rcon_d;
            rc_q    <= rc_d;
            key_q   <= key_d;
        end
    end

    assign bus.round_valid = (state_q == RUN);
    assign bus.busy        = (state_q == RUN);
    assign bus.done        = (state_q == FIN);
    assign bus.rcon        = rcon_q;
    assign bus.rc          = rc_q;
    assign bus.rk_u        = key_q[95:64];
    assign bus.rk_v        = key_q[31:0];
endmodule

// File: tb/tb_gift_round_ctrl.sv
// Self-checking bench for gift_round_ctrl: directed plan steps plus a
// randomized phase, all compared against a word-level schedule model.
module tb_gift_round_ctrl;
    localparam int ROUNDS = 28;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    gift_round_ctrl_if bus();

    gift_round_ctrl #(.ROUNDS(ROUNDS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [5:0]  rc_tab [28] = '{
        6'h01, 6'h03, 6'h07, 6'h0F, 6'h1F, 6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F,
        6'h1E, 6'h3C, 6'h39, 6'h33, 6'h27, 6'h0E, 6'h1D, 6'h3A, 6'h35, 6'h2B,
        6'h16, 6'h2C, 6'h18, 6'h30, 6'h21, 6'h02, 6'h05, 6'h0B
    };

    bit          m_run;
    bit          m_done;
    int          m_round;
    logic [15:0] m_w [8];

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] rotr(input logic [15:0] x, input int n);
        int v;
        v = int'(x);
        return 16'(((v >> n) | (v << (16 - n))) & 32'hFFFF);
    endfunction

    task automatic model_step();
        logic [15:0] o [8];
        if (rst) begin
            m_run = 0; m_done = 0; m_round = 0;
            foreach (m_w[i]) m_w[i] = '0;
        end else if (m_done) begin
            m_done = 0;
        end else if (!m_run) begin
            if (bus.start) begin
                m_run = 1; m_round = 1;
                foreach (m_w[i]) m_w[i] = bus.key_in[16*i +: 16];
            end
        end else if (bus.round_ready) begin
            if (m_round == ROUNDS) begin
                m_run = 0; m_done = 1; m_round = 0;
                foreach (m_w[i]) m_w[i] = '0;
            end else begin
                m_round++;
                o = m_w;
                for (int i = 0; i < 6; i++) m_w[i] = o[i+2];
                m_w[7] = rotr(o[1], 2);
                m_w[6] = rotr(o[0], 12);
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("valid", bus.round_valid, m_run);
        chk("busy", bus.busy, m_run);
        chk("done", bus.done, m_done);
        chk("rcon", bus.rcon, m_round);
        chk("rc", bus.rc, (m_round > 0) ? rc_tab[m_round-1] : 6'h00);
        chk("rk_u", bus.rk_u, {m_w[5], m_w[4]});
        chk("rk_v", bus.rk_v, {m_w[1], m_w[0]});
    endtask

    function automatic logic [127:0] rkey();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    logic [127:0] k2;
    logic [31:0]  hold_u, hold_v;

    initial begin
        checks = 0; failures = 0;
        m_run = 0; m_done = 0; m_round = 0;
        foreach (m_w[i]) m_w[i] = '0;
        rst = 1; bus.start = 0; bus.key_in = '0; bus.round_ready = 0;
        #1;
        tick(); tick();
        rst = 0;
        chk("rst_idle_rcon", bus.rcon, 5'd0);
        chk("rst_idle_rk", {bus.rk_u, bus.rk_v}, 64'd0);

        bus.key_in = 128'h0001_0002_0003_0004_0005_0006_0007_0008;
        bus.start = 1;
        tick();
        bus.start = 0; bus.round_ready = 1;
        chk("r1_rcon", bus.rcon, 5'd1);
        chk("r1_rc", bus.rc, 6'h01);
        chk("r1_rk_u", bus.rk_u, 32'h0003_0004);
        chk("r1_rk_v", bus.rk_v, 32'h0007_0008);
        tick();
        chk("r2_rk_u", bus.rk_u, 32'h0001_0002);
        chk("r2_rk_v", bus.rk_v, 32'h0005_0006);
        tick();
        chk("r3_rk_u_k7k6", bus.rk_u, 32'hC001_0080);

        bus.start = 1; bus.key_in = rkey();
        tick();
        bus.start = 0;
        chk("ign_start_rcon", bus.rcon, 5'd4);
        repeat (2) tick();
        chk("r6_rc", bus.rc, 6'h3E);
        repeat (4) tick();
        chk("r10_rc", bus.rc, 6'h2F);
        hold_u = bus.rk_u; hold_v = bus.rk_v;
        bus.round_ready = 0;
        repeat (5) tick();
        chk("stall_rcon", bus.rcon, 5'd10);
        chk("stall_rc", bus.rc, 6'h2F);
        chk("stall_rk", {bus.rk_u, bus.rk_v}, {hold_u, hold_v});
        bus.round_ready = 1;
        tick();
        chk("resume_rcon", bus.rcon, 5'd11);
        chk("resume_rc", bus.rc, 6'h1E);
        repeat (17) tick();
        chk("r28_rcon", bus.rcon, 5'd28);
        chk("r28_rc", bus.rc, 6'h0B);
        tick();
        chk("fin_done", bus.done, 1'b1);
        chk("fin_rcon", bus.rcon, 5'd0);

        k2 = rkey();
        bus.start = 1; bus.key_in = k2;
        tick();
        chk("fin_start_ignored", bus.round_valid, 1'b0);
        tick();
        bus.start = 0;
        chk("b2b_valid", bus.round_valid, 1'b1);
        chk("b2b_rc", bus.rc, 6'h01);
        chk("b2b_rk", {bus.rk_u, bus.rk_v}, {k2[95:64], k2[31:0]});

        repeat (4) tick();
        chk("pre_rst_rcon", bus.rcon, 5'd5);
        rst = 1;
        tick(); tick();
        rst = 0;
        chk("rst_run_rcon", bus.rcon, 5'd0);
        chk("rst_run_valid", bus.round_valid, 1'b0);
        bus.start = 1; bus.key_in = rkey();
        tick();
        bus.start = 0;
        chk("restart_rcon", bus.rcon, 5'd1);
        repeat (28) tick();
        chk("fin2_done", bus.done, 1'b1);
        rst = 1;
        tick(); tick();
        rst = 0;
        chk("rst_fin_done", bus.done, 1'b0);

        for (int i = 0; i < 1500; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            bus.start = ($urandom_range(0, 3) == 0);
            bus.key_in = rkey();
            bus.round_ready = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/gift_round_ctrl.md
Name: gift_round_ctrl

Overview:
- Iterative round controller and key schedule for the GIFT-128 datapath.
- Sits directly upstream of the round-constant stage. Supplies the round index `rcon` that the stage consumes, the matching 6-bit LFSR constant `rc`, and the 32-bit round-key halves U/V for AddRoundKey.
- Sequences rounds 1..ROUNDS under a start/ready/done handshake with the state datapath.

Parameters:
- ROUNDS, 28, number of rounds sequenced. Must be 1..28, the range covered by the constant stage's table.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a new key schedule; honoured only in IDLE.
- key_in  in  128  master key. Word k7 = [127:112] down to k0 = [15:0]. Sampled on an accepted start.
- round_ready  in  1  datapath has consumed the current round's outputs.
- round_valid  out  1  rcon/rc/U/V are valid for the current round.
- rcon  out  5  current round index, 1..ROUNDS; 0 when not running.
- rc  out  6  current round constant (c5..c0).
- rk_u  out  32  round-key half U = k5||k4.
- rk_v  out  32  round-key half V = k1||k0.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse after the last round is accepted.

Behaviour:
- States: IDLE, RUN, FIN.
- Reset: rst=1 at a clock edge forces IDLE and clears all outputs and registers. After reset, round_valid=0, busy=0, done=0, rcon=0, rc=0, rk_u=0, rk_v=0. This applies in any state, including mid-RUN; the partial schedule is discarded.
- IDLE + start=1:
  - Load the key register from key_in.
  - Set rcon=1 and rc=6'b000001.
  - Go to RUN. From the next cycle, round_valid=1 and busy=1.
  - Latency from start to the first valid round is 1 cycle.
- IDLE + start=0: hold.
- RUN with round_valid=1 and round_ready=1 (accept):
  - If rcon==ROUNDS: go to FIN and drop round_valid and busy.
  - Otherwise, on the same edge:
    - rcon <= rcon+1.
    - rc <= {rc[4:0], rc[5]^rc[4]^1}.
    - Key update on words k7..k0: new (k7,k6,k5,k4,k3,k2,k1,k0) = (k1 rotr 2, k0 rotr 12, k7, k6, k5, k4, k3, k2). Rotations are within 16 bits.
- RUN + round_ready=0: all outputs hold stable (stall). There is no limit on stall length.
- FIN: done=1 for exactly one cycle, rcon returns to 0, then go to IDLE. start is ignored in FIN.
- start in RUN or FIN: ignored. The current schedule is not restarted.
- start and round_ready both high in RUN: round_ready governs and start is ignored.
- ROUNDS=1: the first accept goes straight to FIN.
- rk_u and rk_v are combinational views of the current key register. They are zero in IDLE.
- rc sequence for rounds 1..28: 01,03,07,0F,1F,3E,3D,3B,37,2F,1E,3C,39,33,27,0E,1D,3A,35,2B,16,2C,18,30,21,02,05,0B (hex).
- Back-to-back operation: a start in the cycle after the done pulse (IDLE) is accepted.

Test Plan:
- Reset values:
  - Stimulus: assert rst for 2 cycles in each of IDLE, RUN at rcon=5, and FIN.
  - Response: next cycle round_valid=0, busy=0, done=0, rcon=0, rc=0, rk_u=0, rk_v=0. A start then begins cleanly at rcon=1.
- Key schedule:
  - Stimulus: key_in=0x0001_0002_0003_0004_0005_0006_0007_0008, start, round_ready held 1.
  - Response, round 1: rk_u=0x00030004, rk_v=0x00070008.
  - Response, round 2: rk_u=0x00010002, rk_v=0x00050006, and key words k7=0xC001, k6=0x0080.
- Constant sequence:
  - Stimulus: any key, round_ready=1 continuously.
  - Response: rcon steps 1..28 on consecutive cycles. rc=0x01 at round 1, 0x3E at round 6, 0x0B at round 28. done pulses once, 1 cycle after the round-28 accept.
- Stall:
  - Stimulus: drop round_ready for 5 cycles at rcon=10.
  - Response: rcon=10, rc=0x2F and rk_u/rk_v are unchanged throughout. The sequence resumes at rcon=11, rc=0x1E.
- Ignored start:
  - Stimulus: pulse start with a different key_in while rcon=3.
  - Response: the sequence continues unchanged and the done timing is unaffected.
- Back-to-back:
  - Stimulus: start the cycle after done.
  - Response: round_valid=1 with rcon=1, rc=0x01, and rk_u/rk_v taken from the new key.
